// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
//   Slots are allocated in order at the tail. Up to WB_PORTS writebacks per
//   cycle complete slots out of order. Slots commit in order from the head.
//   A head entry that carries an exception is reported on except/pc/address
//   and flushes the whole buffer at the following edge.
// Build option:
//   ROB_DUAL_COMMIT_EN - when defined, head+1 may commit in the same cycle as
//   the head through a second commit port (wDstReg1/wData1/wEnable1).
module rob_param #(
    parameter int ARCH_BITS    = 32,
    parameter int REG_IDX_BITS = 5,
    parameter int ROB_SLOTS    = 8,
    parameter int ROB_IDX_BITS = 3,
    parameter int WB_PORTS     = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    // allocation from decode/issue
    input  logic                             allocReq,
    output logic                             allocReady,
    output logic [ROB_IDX_BITS-1:0]          allocIdx,
    // writeback ports, port p occupies slice p of each bus
    input  logic [WB_PORTS-1:0]              wbValid,
    input  logic [WB_PORTS*ROB_IDX_BITS-1:0] wbRobIdx,
    input  logic [WB_PORTS-1:0]              wbExcept,
    input  logic [WB_PORTS*ARCH_BITS-1:0]    wbPc,
    input  logic [WB_PORTS*ARCH_BITS-1:0]    wbAddr,
    input  logic [WB_PORTS*ARCH_BITS-1:0]    wbData,
    input  logic [WB_PORTS*REG_IDX_BITS-1:0] wbDst,
    input  logic [WB_PORTS-1:0]              wbWe,
    // exception report of the head entry
    output logic                             except,
    output logic [ARCH_BITS-1:0]             address,
    output logic [ARCH_BITS-1:0]             pc,
    // commit port 0 (oldest entry)
    output logic [REG_IDX_BITS-1:0]          wDstReg0,
    output logic [ARCH_BITS-1:0]             wData0,
    output logic                             wEnable0,
`ifdef ROB_DUAL_COMMIT_EN
    // commit port 1 (head+1, younger than port 0)
    output logic [REG_IDX_BITS-1:0]          wDstReg1,
    output logic [ARCH_BITS-1:0]             wData1,
    output logic                             wEnable1,
`endif
    // occupancy
    output logic [ROB_IDX_BITS:0]            count,
    output logic                             empty
);

    // Width of a writeback port selector; at least one bit so a single-port
    // build still has a legal vector.
    localparam int SEL_BITS = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
    localparam logic [ROB_IDX_BITS:0] FULL_COUNT = (ROB_IDX_BITS + 1)'(ROB_SLOTS);
    localparam logic [ROB_IDX_BITS-1:0] IDX_ONE = ROB_IDX_BITS'(1);

    // ------------------------------------------------------------------
    // Pointer / occupancy state
    // ------------------------------------------------------------------
    logic [ROB_IDX_BITS-1:0] head_reg, head_next;
    logic [ROB_IDX_BITS-1:0] tail_reg, tail_next;
    logic [ROB_IDX_BITS:0]   count_reg, count_next;

    // ------------------------------------------------------------------
    // Per-slot state. Control bits live in packed vectors so a single
    // process owns each of them; the payload is plain storage.
    // ------------------------------------------------------------------
    logic [ROB_SLOTS-1:0]    alloc_reg, alloc_next;
    logic [ROB_SLOTS-1:0]    done_reg, done_next;
    logic [ROB_SLOTS-1:0]    exc_reg;
    logic [ROB_SLOTS-1:0]    we_reg;
    logic [ARCH_BITS-1:0]    slot_pc_reg   [ROB_SLOTS];
    logic [ARCH_BITS-1:0]    slot_addr_reg [ROB_SLOTS];
    logic [ARCH_BITS-1:0]    slot_data_reg [ROB_SLOTS];
    logic [REG_IDX_BITS-1:0] slot_dst_reg  [ROB_SLOTS];

    // ------------------------------------------------------------------
    // Writeback buses split into per-port fields
    // ------------------------------------------------------------------
    logic [ROB_IDX_BITS-1:0] wb_idx  [WB_PORTS];
    logic [ARCH_BITS-1:0]    wb_pc   [WB_PORTS];
    logic [ARCH_BITS-1:0]    wb_addr [WB_PORTS];
    logic [ARCH_BITS-1:0]    wb_data [WB_PORTS];
    logic [REG_IDX_BITS-1:0] wb_dst  [WB_PORTS];

    generate
        for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_port
            assign wb_idx[gi]  = wbRobIdx[gi*ROB_IDX_BITS +: ROB_IDX_BITS];
            assign wb_pc[gi]   = wbPc[gi*ARCH_BITS +: ARCH_BITS];
            assign wb_addr[gi] = wbAddr[gi*ARCH_BITS +: ARCH_BITS];
            assign wb_data[gi] = wbData[gi*ARCH_BITS +: ARCH_BITS];
            assign wb_dst[gi]  = wbDst[gi*REG_IDX_BITS +: REG_IDX_BITS];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-slot writeback arbitration: which port (if any) targets the slot.
    // Ports are scanned from highest to lowest so the lowest index wins.
    // ------------------------------------------------------------------
    logic [ROB_SLOTS-1:0] wb_hit;
    logic [ROB_SLOTS-1:0] wb_accept;
    logic [SEL_BITS-1:0]  wb_sel [ROB_SLOTS];

    generate
        for (genvar gi = 0; gi < ROB_SLOTS; gi++) begin : g_slot
            logic                hit;
            logic [SEL_BITS-1:0] sel;

            // Pick the lowest-numbered valid port addressing this slot
            always_comb begin
                hit = 1'b0;
                sel = '0;
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    if (wbValid[p] && (wb_idx[p] == ROB_IDX_BITS'(gi))) begin
                        hit = 1'b1;
                        sel = SEL_BITS'(p);
                    end
                end
            end

            assign wb_hit[gi]    = hit;
            assign wb_sel[gi]    = sel;
            // Only slots already allocated before this edge take a writeback
            assign wb_accept[gi] = hit & alloc_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Commit decision, purely from the current head state
    // ------------------------------------------------------------------
    logic                 head_ok;
    logic                 commit0;
    logic                 commit1;
    logic                 flush;
    logic [1:0]           n_commit;
    logic [ROB_SLOTS-1:0] retire_mask;
`ifdef ROB_DUAL_COMMIT_EN
    logic [ROB_IDX_BITS-1:0] head1;
`endif

    // Head commit / exception detection and optional second commit
    always_comb begin
        head_ok     = alloc_reg[head_reg] & done_reg[head_reg];
        commit0     = head_ok & ~exc_reg[head_reg];
        flush       = head_ok & exc_reg[head_reg];
        commit1     = 1'b0;
        retire_mask = '0;
        if (commit0) begin
            retire_mask[head_reg] = 1'b1;
        end
`ifdef ROB_DUAL_COMMIT_EN
        head1 = head_reg + IDX_ONE;
        // head+1 rides along only behind a clean head commit
        commit1 = commit0 & alloc_reg[head1] & done_reg[head1] & ~exc_reg[head1];
        if (commit1) begin
            retire_mask[head1] = 1'b1;
        end
`endif
        n_commit = {1'b0, commit0} + {1'b0, commit1};
    end

    // ------------------------------------------------------------------
    // Allocation handshake; readiness looks at the current count only, so a
    // commit in the same cycle never opens a slot for a full buffer.
    // ------------------------------------------------------------------
    logic alloc_fire;

    assign allocReady = (count_reg != FULL_COUNT);
    assign allocIdx   = tail_reg;
    assign alloc_fire = allocReq & allocReady;
    assign count      = count_reg;
    assign empty      = (count_reg == '0);

    // Commit and exception outputs driven from the head slot(s)
    always_comb begin
        except   = flush;
        pc       = slot_pc_reg[head_reg];
        address  = slot_addr_reg[head_reg];
        wDstReg0 = slot_dst_reg[head_reg];
        wData0   = slot_data_reg[head_reg];
        wEnable0 = commit0 & we_reg[head_reg];
`ifdef ROB_DUAL_COMMIT_EN
        wDstReg1 = slot_dst_reg[head1];
        wData1   = slot_data_reg[head1];
        wEnable1 = commit1 & we_reg[head1];
`endif
    end

    // Next-state for pointers, occupancy and per-slot alloc/done bits
    always_comb begin
        head_next  = head_reg + ROB_IDX_BITS'(n_commit);
        tail_next  = alloc_fire ? (tail_reg + IDX_ONE) : tail_reg;
        count_next = count_reg + (ROB_IDX_BITS + 1)'(alloc_fire)
                               - (ROB_IDX_BITS + 1)'(n_commit);
        alloc_next = alloc_reg;
        done_next  = done_reg | wb_accept;
        // A fresh allocation starts incomplete
        if (alloc_fire) begin
            alloc_next[tail_reg] = 1'b1;
            done_next[tail_reg]  = 1'b0;
        end
        // Retired slots become free
        alloc_next = alloc_next & ~retire_mask;
        done_next  = done_next & ~retire_mask;
    end

    // Control state register; reset, clear and an exception flush all empty the buffer
    always_ff @(posedge clk) begin
        if (rst || clear || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            alloc_reg <= '0;
            done_reg  <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            alloc_reg <= alloc_next;
            done_reg  <= done_next;
        end
    end

    // Payload capture; contents are only observed once done is set, so no reset
    always_ff @(posedge clk) begin
        for (int s = 0; s < ROB_SLOTS; s++) begin
            if (wb_accept[s]) begin
                exc_reg[s]       <= wbExcept[wb_sel[s]];
                we_reg[s]        <= wbWe[wb_sel[s]];
                slot_pc_reg[s]   <= wb_pc[wb_sel[s]];
                slot_addr_reg[s] <= wb_addr[wb_sel[s]];
                slot_data_reg[s] <= wb_data[wb_sel[s]];
                slot_dst_reg[s]  <= wb_dst[wb_sel[s]];
            end
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: scoreboard bench for rob_param.
//   The stimulus process keeps a program-order model of the buffer (a queue of
//   allocated slots plus per-slot completion data) and pushes the expected
//   commit for every cycle into exp_q. A separate monitor pops exp_q at each
//   falling edge and compares it with the commit/exception outputs.
module tb_rob_param;
    localparam int AB = 32;
    localparam int RB = 5;
    localparam int NS = 8;
    localparam int IB = 3;
    localparam int NP = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              allocReq = 1'b0;
    logic              allocReady;
    logic [IB-1:0]     allocIdx;
    logic [NP-1:0]     wbValid = '0;
    logic [NP*IB-1:0]  wbRobIdx = '0;
    logic [NP-1:0]     wbExcept = '0;
    logic [NP*AB-1:0]  wbPc = '0;
    logic [NP*AB-1:0]  wbAddr = '0;
    logic [NP*AB-1:0]  wbData = '0;
    logic [NP*RB-1:0]  wbDst = '0;
    logic [NP-1:0]     wbWe = '0;
    logic              except;
    logic [AB-1:0]     address;
    logic [AB-1:0]     pc;
    logic [RB-1:0]     wDstReg0;
    logic [AB-1:0]     wData0;
    logic              wEnable0;
`ifdef ROB_DUAL_COMMIT_EN
    logic [RB-1:0]     wDstReg1;
    logic [AB-1:0]     wData1;
    logic              wEnable1;
`endif
    logic [IB:0]       count;
    logic              empty;

    rob_param #(
        .ARCH_BITS(AB), .REG_IDX_BITS(RB), .ROB_SLOTS(NS),
        .ROB_IDX_BITS(IB), .WB_PORTS(NP)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .allocReq(allocReq), .allocReady(allocReady), .allocIdx(allocIdx),
        .wbValid(wbValid), .wbRobIdx(wbRobIdx), .wbExcept(wbExcept),
        .wbPc(wbPc), .wbAddr(wbAddr), .wbData(wbData), .wbDst(wbDst), .wbWe(wbWe),
        .except(except), .address(address), .pc(pc),
        .wDstReg0(wDstReg0), .wData0(wData0), .wEnable0(wEnable0),
`ifdef ROB_DUAL_COMMIT_EN
        .wDstReg1(wDstReg1), .wData1(wData1), .wEnable1(wEnable1),
`endif
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          port;
        bit          we;
        bit          exc;
        logic [RB-1:0] dst;
        logic [AB-1:0] data;
        logic [AB-1:0] pc;
        logic [AB-1:0] addr;
    } rec_t;

    rec_t exp_q[$];

    // Reference model: slots in allocation order, oldest first
    int            prog_q[$];
    bit            m_done [NS];
    bit            m_exc  [NS];
    bit            m_we   [NS];
    logic [AB-1:0] m_pc   [NS];
    logic [AB-1:0] m_addr [NS];
    logic [AB-1:0] m_data [NS];
    logic [RB-1:0] m_dst  [NS];
    int            m_tail = 0;
    bit            model_valid = 1'b0;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Pending writeback stimulus for the next step
    bit            t_v   [NP];
    int            t_s   [NP];
    bit            t_e   [NP];
    bit            t_w   [NP];
    logic [AB-1:0] t_pc  [NP];
    logic [AB-1:0] t_ad  [NP];
    logic [AB-1:0] t_d   [NP];
    logic [RB-1:0] t_dst [NP];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_rob(input int s);
        foreach (prog_q[i]) if (prog_q[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic rec_t mk_rec(input int s, input int port);
        rec_t r;
        r.cyc = cyc; r.port = port; r.we = m_we[s]; r.exc = m_exc[s];
        r.dst = m_dst[s]; r.data = m_data[s]; r.pc = m_pc[s]; r.addr = m_addr[s];
        return r;
    endfunction

    task automatic model_reset();
        prog_q.delete();
        m_tail = 0;
        for (int i = 0; i < NS; i++) m_done[i] = 1'b0;
    endtask

    task automatic clear_wb();
        for (int p = 0; p < NP; p++) begin
            t_v[p] = 1'b0; t_s[p] = 0; t_e[p] = 1'b0; t_w[p] = 1'b0;
            t_pc[p] = '0; t_ad[p] = '0; t_d[p] = '0; t_dst[p] = '0;
        end
    endtask

    task automatic set_wb(input int p, input int s, input bit e, input bit w,
                          input logic [AB-1:0] pcv, input logic [AB-1:0] adv,
                          input logic [AB-1:0] dv, input logic [RB-1:0] dst);
        t_v[p] = 1'b1; t_s[p] = s; t_e[p] = e; t_w[p] = w;
        t_pc[p] = pcv; t_ad[p] = adv; t_d[p] = dv; t_dst[p] = dst;
    endtask

    // One clock cycle: drive inputs, check occupancy, predict commits, advance model
    task automatic step(input bit a_req, input bit r, input bit c);
        bit acc;
        bit flush;
        int n_commit;
        bit taken [NS];
        rst = r; clear = c; allocReq = a_req;
        for (int p = 0; p < NP; p++) begin
            wbValid[p] = t_v[p];
            wbRobIdx[p*IB +: IB] = IB'(t_s[p]);
            wbExcept[p] = t_e[p];
            wbWe[p] = t_w[p];
            wbPc[p*AB +: AB] = t_pc[p];
            wbAddr[p*AB +: AB] = t_ad[p];
            wbData[p*AB +: AB] = t_d[p];
            wbDst[p*RB +: RB] = t_dst[p];
        end
        flush = 1'b0;
        n_commit = 0;
        if (model_valid) begin
            chk("allocReady", allocReady, prog_q.size() < NS);
            chk("allocIdx", allocIdx, m_tail);
            chk("count", count, prog_q.size());
            chk("empty", empty, prog_q.size() == 0);
            if (prog_q.size() > 0 && m_done[prog_q[0]]) begin
                exp_q.push_back(mk_rec(prog_q[0], 0));
                if (m_exc[prog_q[0]]) flush = 1'b1;
                else n_commit = 1;
`ifdef ROB_DUAL_COMMIT_EN
                if (!flush && prog_q.size() > 1 && m_done[prog_q[1]] && !m_exc[prog_q[1]]) begin
                    exp_q.push_back(mk_rec(prog_q[1], 1));
                    n_commit = 2;
                end
`endif
            end
        end
        if (r || c || flush) begin
            model_reset();
        end else begin
            acc = a_req && (prog_q.size() < NS);
            for (int i = 0; i < NS; i++) taken[i] = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (t_v[p] && !taken[t_s[p]] && in_rob(t_s[p])) begin
                    taken[t_s[p]] = 1'b1;
                    m_done[t_s[p]] = 1'b1; m_exc[t_s[p]] = t_e[p]; m_we[t_s[p]] = t_w[p];
                    m_pc[t_s[p]] = t_pc[p]; m_addr[t_s[p]] = t_ad[p];
                    m_data[t_s[p]] = t_d[p]; m_dst[t_s[p]] = t_dst[p];
                end
            end
            repeat (n_commit) void'(prog_q.pop_front());
            if (acc) begin
                prog_q.push_back(m_tail);
                m_done[m_tail] = 1'b0;
                m_tail = (m_tail + 1) % NS;
            end
        end
        @(posedge clk);
        #1;
        if (r) model_valid = 1'b1;
    endtask

    // Monitor: compare the commit ports with the scoreboard every cycle
    always @(negedge clk) begin
        rec_t rr;
        if (model_valid) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].port == 0) begin
                rr = exp_q.pop_front();
                chk("except", except, rr.exc);
                chk("wEnable0", wEnable0, rr.we && !rr.exc);
                if (rr.exc) begin
                    chk("exc_pc", pc, rr.pc);
                    chk("exc_address", address, rr.addr);
                end else if (rr.we) begin
                    chk("wDstReg0", wDstReg0, rr.dst);
                    chk("wData0", wData0, rr.data);
                end
                $display("commit cyc=%0d port0 exc=%0b we=%0b dst=%0d data=0x%0h pc=0x%0h",
                         cyc, except, wEnable0, wDstReg0, wData0, pc);
            end else begin
                chk("idle_port0", {wEnable0, except}, 2'b00);
            end
`ifdef ROB_DUAL_COMMIT_EN
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].port == 1) begin
                rr = exp_q.pop_front();
                chk("wEnable1", wEnable1, rr.we);
                if (rr.we) begin
                    chk("wDstReg1", wDstReg1, rr.dst);
                    chk("wData1", wData1, rr.data);
                end
                $display("commit cyc=%0d port1 we=%0b dst=%0d data=0x%0h",
                         cyc, wEnable1, wDstReg1, wData1);
            end else begin
                chk("idle_port1", wEnable1, 1'b0);
            end
`endif
        end
    end

    initial begin
        int pend[$];
        int last;
        int s;
        clear_wb();
        @(posedge clk);
        #1;

        // Reset held for two cycles
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_allocReady", allocReady, 1'b1);
        chk("rst_allocIdx", allocIdx, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_wEnable0", wEnable0, 1'b0);
        chk("rst_except", except, 1'b0);

        // Fill the buffer, then try a ninth allocation
        for (int i = 0; i < NS; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("full_allocReady", allocReady, 1'b0);
        chk("full_tail", allocIdx, 0);
        chk("full_count", count, 8);

        // Out-of-order completion: slot2, slot0, slot1
        set_wb(0, 2, 1'b0, 1'b1, 32'h8, 32'h0, 32'hAA, 5'd5); step(1'b0, 1'b0, 1'b0); clear_wb();
        set_wb(1, 0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h10, 5'd1); step(1'b0, 1'b0, 1'b0); clear_wb();
        set_wb(2, 1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h20, 5'd2); step(1'b0, 1'b0, 1'b0); clear_wb();
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("ooo_count", count, 5);
        step(1'b0, 1'b0, 1'b1);

        // Exception on slot1 after slot0 completes
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        set_wb(0, 0, 1'b0, 1'b1, 32'h3C, 32'h0, 32'h5, 5'd3); step(1'b0, 1'b0, 1'b0); clear_wb();
        set_wb(0, 1, 1'b1, 1'b1, 32'h40, 32'h1000, 32'h6, 5'd4); step(1'b0, 1'b0, 1'b0); clear_wb();
        step(1'b0, 1'b0, 1'b0);
        chk("exc_empty", empty, 1'b1);
        chk("exc_count", count, 0);

        // Same-slot conflict on ports 0 and 2
        repeat (4) step(1'b1, 1'b0, 1'b0);
        set_wb(0, 3, 1'b0, 1'b1, 32'h0, 32'h0, 32'h11, 5'd7);
        set_wb(2, 3, 1'b0, 1'b1, 32'h0, 32'h0, 32'h22, 5'd8);
        set_wb(1, 0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h30, 5'd9);
        step(1'b0, 1'b0, 1'b0); clear_wb();
        set_wb(0, 1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h31, 5'd10);
        set_wb(1, 2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h32, 5'd11);
        step(1'b0, 1'b0, 1'b0); clear_wb();
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("conflict_empty", empty, 1'b1);

        // Twenty allocate/complete pairs to wrap both pointers
        last = -1;
        for (int i = 0; i < 20; i++) begin
            if (last >= 0) set_wb(i % NP, last, 1'b0, 1'b1, 32'h0, 32'h0, 32'(i), 5'(i));
            last = m_tail;
            step(1'b1, 1'b0, 1'b0);
            clear_wb();
        end
        set_wb(0, last, 1'b0, 1'b1, 32'h0, 32'h0, 32'h99, 5'd31);
        step(1'b0, 1'b0, 1'b0); clear_wb();
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("wrap_empty", empty, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            clear_wb();
            pend.delete();
            foreach (prog_q[k]) if (!m_done[prog_q[k]]) pend.push_back(prog_q[k]);
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 99) < 50) begin
                    if ($urandom_range(0, 9) == 0 || pend.size() == 0) s = $urandom_range(0, NS - 1);
                    else s = pend[$urandom_range(0, pend.size() - 1)];
                    if (!(in_rob(s) && m_done[s]))
                        set_wb(p, s, $urandom_range(0, 29) == 0, $urandom_range(0, 5) != 0,
                               $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
                end
            end
            step($urandom_range(0, 99) < 65, 1'b0, $urandom_range(0, 199) == 0);
        end

        // Drain: complete everything outstanding, bounded
        for (int i = 0; i < 200 && prog_q.size() > 0; i++) begin
            clear_wb();
            pend.delete();
            foreach (prog_q[k]) if (!m_done[prog_q[k]]) pend.push_back(prog_q[k]);
            for (int p = 0; p < NP && p < pend.size(); p++)
                set_wb(p, pend[p], 1'b0, 1'b1, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
            step(1'b0, 1'b0, 1'b0);
        end
        clear_wb();
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("drain_empty", empty, 1'b1);
        chk("drain_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
